// File: rtl/datapath_controller_if.sv
// Host/datapath-facing bundle for the datapath controller: instruction
// handshake from the host plus every datapath control line.
interface datapath_controller_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] in;
    logic              load;
    logic              s;
    logic              w;
    logic              bad_instr;
    logic [2:0]        readnum;
    logic [2:0]        writenum;
    logic              write;
    logic              loada;
    logic              loadb;
    logic              loadc;
    logic              loads;
    logic              asel;
    logic              bsel;
    logic              vsel;
    logic [1:0]        shift;
    logic [1:0]        ALUop;
    logic [DATA_W-1:0] datapath_in;

    modport master (
        output in, load, s,
        input  w, bad_instr, readnum, writenum, write, loada, loadb, loadc,
               loads, asel, bsel, vsel, shift, ALUop, datapath_in
    );

    modport slave (
        input  in, load, s,
        output w, bad_instr, readnum, writenum, write, loada, loadb, loadc,
               loads, asel, bsel, vsel, shift, ALUop, datapath_in
    );
endinterface

// File: rtl/datapath_controller.sv
// Instruction register plus Moore control FSM that sequences the 16-bit
// datapath one step per clock for MOV/ADD/CMP/AND/MVN.
module datapath_controller #(
    parameter int DATA_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    datapath_controller_if.slave bus
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_WRITE_IMM,
        S_GET_A,
        S_GET_B,
        S_EXEC,
        S_WRITE_REG
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] ir;

    logic [2:0]        opc;
    logic [1:0]        op;
    logic [2:0]        rn;
    logic [2:0]        rd;
    logic [1:0]        sh;
    logic [2:0]        rm;
    logic [DATA_W-1:0] sximm8;

    assign opc    = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];
    assign sximm8 = {{(DATA_W-8){ir[7]}}, ir[7:0]};

    logic is_mov_imm;
    logic is_mov_reg;
    logic is_alu;
    logic is_cmp;
    logic is_mvn;

    assign is_mov_imm = (opc == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opc == 3'b110) && (op == 2'b00);
    assign is_alu     = (opc == 3'b101);
    assign is_cmp     = is_alu && (op == 2'b01);
    assign is_mvn     = is_alu && (op == 2'b11);

    // NOTE: state and IR are registers, so they take non-blocking assignments;
    // blocking here would let same-edge readers see the new value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_WAIT;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_WAIT && bus.load)
                ir <= bus.in;
        end
    end

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_WAIT:      if (bus.s) state_nxt = S_DECODE;
            S_DECODE: begin
                if (is_mov_imm)                      state_nxt = S_WRITE_IMM;
                else if (is_mov_reg || is_mvn)       state_nxt = S_GET_B;
                else if (is_alu)                     state_nxt = S_GET_A;
                else                                 state_nxt = S_WAIT;
            end
            S_GET_A:     state_nxt = S_GET_B;
            S_GET_B:     state_nxt = S_EXEC;
            S_EXEC:      state_nxt = is_cmp ? S_WAIT : S_WRITE_REG;
            S_WRITE_IMM: state_nxt = S_WAIT;
            S_WRITE_REG: state_nxt = S_WAIT;
            default:     state_nxt = S_WAIT;
        endcase
    end

    always_comb begin
        bus.w           = 1'b0;
        bus.bad_instr   = 1'b0;
        bus.readnum     = 3'd0;
        bus.writenum    = 3'd0;
        bus.write       = 1'b0;
        bus.loada       = 1'b0;
        bus.loadb       = 1'b0;
        bus.loadc       = 1'b0;
        bus.loads       = 1'b0;
        bus.asel        = 1'b0;
        bus.bsel        = 1'b0;
        bus.vsel        = 1'b0;
        bus.shift       = 2'b00;
        bus.ALUop       = 2'b00;
        bus.datapath_in = '0;
        case (state)
            S_WAIT:   bus.w = 1'b1;
            S_DECODE: bus.bad_instr = !(is_mov_imm || is_mov_reg || is_alu);
            S_GET_A: begin
                bus.readnum = rn;
                bus.loada   = 1'b1;
            end
            S_GET_B: begin
                bus.readnum = rm;
                bus.loadb   = 1'b1;
            end
            S_EXEC: begin
                bus.shift = sh;
                bus.loadc = 1'b1;
                bus.ALUop = is_alu ? op : 2'b00;
                // Single-operand ops zero the A side so the ALU passes B through.
                bus.asel  = is_mov_reg || is_mvn;
                bus.loads = is_cmp;
            end
            S_WRITE_REG: begin
                bus.writenum = rd;
                bus.write    = 1'b1;
            end
            S_WRITE_IMM: begin
                bus.writenum    = rn;
                bus.write       = 1'b1;
                bus.vsel        = 1'b1;
                bus.datapath_in = sximm8;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_datapath_controller.sv
// Self-checking bench: a behavioural datapath driven by the controller's
// outputs, compared against an instruction-level register/flag model.
module tb_datapath_controller;

    logic clk;
    logic rst_n;

    datapath_controller_if #(.DATA_W(16)) bus ();

    datapath_controller #(.DATA_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural datapath: register file, A/B/C, shifter, ALU, Z flag.
    logic [15:0] rf [8];
    logic [15:0] ra, rb, rc;
    logic        zf;
    logic [15:0] ain, bin, alu_out;

    function automatic logic [15:0] dp_shift(input logic [15:0] b, input logic [1:0] sh);
        case (sh)
            2'b00:   return b;
            2'b01:   return {b[14:0], 1'b0};
            2'b10:   return {1'b0, b[15:1]};
            default: return {b[15], b[15:1]};
        endcase
    endfunction

    always_comb begin
        ain = bus.asel ? 16'h0 : ra;
        bin = bus.bsel ? 16'h0 : dp_shift(rb, bus.shift);
        case (bus.ALUop)
            2'b00:   alu_out = ain + bin;
            2'b01:   alu_out = ain - bin;
            2'b10:   alu_out = ain & bin;
            default: alu_out = ~bin;
        endcase
    end

    always @(posedge clk) begin
        if (bus.write) rf[bus.writenum] <= bus.vsel ? bus.datapath_in : rc;
        if (bus.loada) ra <= rf[bus.readnum];
        if (bus.loadb) rb <= rf[bus.readnum];
        if (bus.loadc) rc <= alu_out;
        if (bus.loads) zf <= (alu_out == 16'h0);
    end

    // Instruction-level reference model.
    typedef enum {K_MOVI, K_MOVR, K_ADD, K_CMP, K_AND, K_MVN, K_BAD} kind_t;

    logic [15:0] mreg [8];
    logic        mz;
    logic [15:0] ir_model;

    function automatic kind_t classify(input logic [15:0] i);
        logic [4:0] key;
        key = i[15:11];
        case (key)
            5'b110_10: return K_MOVI;
            5'b110_00: return K_MOVR;
            5'b101_00: return K_ADD;
            5'b101_01: return K_CMP;
            5'b101_10: return K_AND;
            5'b101_11: return K_MVN;
            default:   return K_BAD;
        endcase
    endfunction

    function automatic int exp_latency(input kind_t k);
        case (k)
            K_MOVI:                return 2;
            K_MOVR, K_MVN, K_CMP:  return 4;
            K_ADD, K_AND:          return 5;
            default:               return 1;
        endcase
    endfunction

    function automatic logic [15:0] m_shift(input logic [15:0] b, input logic [1:0] sh);
        logic signed [15:0] sb;
        sb = b;
        case (sh)
            2'b00:   return b;
            2'b01:   return b + b;
            2'b10:   return b / 16'd2;
            default: return sb >>> 1;
        endcase
    endfunction

    task automatic model_exec(input logic [15:0] i);
        logic [15:0] opb;
        logic [15:0] diff;
        opb = m_shift(mreg[i[2:0]], i[4:3]);
        case (classify(i))
            K_MOVI: mreg[i[10:8]] = {{8{i[7]}}, i[7:0]};
            K_MOVR: mreg[i[7:5]]  = opb;
            K_ADD:  mreg[i[7:5]]  = mreg[i[10:8]] + opb;
            K_AND:  mreg[i[7:5]]  = mreg[i[10:8]] & opb;
            K_MVN:  mreg[i[7:5]]  = ~opb;
            K_CMP: begin
                diff = mreg[i[10:8]] - opb;
                mz   = (diff == 16'h0);
            end
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts one instruction from WAIT and steps until w returns, recording
    // what the control outputs did along the way.
    task automatic run_instr(input logic [15:0] instr, input bit do_load,
                             input int inject_at, input logic [15:0] inject_word,
                             output int lat, output int wr_cnt, output int bad_cnt,
                             output int loads_cnt, output int leak,
                             output logic [2:0] last_wn, output logic [15:0] last_dp);
        wr_cnt = 0; bad_cnt = 0; loads_cnt = 0; leak = 0;
        last_wn = 3'd0; last_dp = 16'h0;
        bus.in = instr; bus.load = do_load; bus.s = 1'b1;
        tick();
        bus.load = 1'b0; bus.s = 1'b0;
        lat = 0;
        while (!bus.w && lat < 20) begin
            if (lat == inject_at) begin
                bus.in   = inject_word;
                bus.load = 1'b1;
            end else begin
                bus.load = 1'b0;
            end
            if (bus.write) begin
                wr_cnt++;
                last_wn = bus.writenum;
                last_dp = bus.datapath_in;
            end
            if (bus.bad_instr) bad_cnt++;
            if (bus.loads) loads_cnt++;
            if (!bus.vsel && bus.datapath_in != 16'h0) leak++;
            tick();
            lat++;
        end
        bus.load = 1'b0;
        if (lat >= 20) check("timeout_w", 32'(lat), 32'(exp_latency(classify(instr))));
    endtask

    task automatic exec_and_check(input logic [15:0] instr, input bit do_load,
                                  input int inject_at, input logic [15:0] inject_word);
        int          lat, wr_cnt, bad_cnt, loads_cnt, leak;
        logic [2:0]  last_wn;
        logic [15:0] last_dp;
        kind_t       k;
        bit          writes;
        if (do_load) ir_model = instr;
        k = classify(ir_model);
        writes = !(k == K_CMP || k == K_BAD);
        run_instr(instr, do_load, inject_at, inject_word,
                  lat, wr_cnt, bad_cnt, loads_cnt, leak, last_wn, last_dp);
        model_exec(ir_model);
        check($sformatf("latency_%h", ir_model), 32'(lat), 32'(exp_latency(k)));
        check($sformatf("writes_%h", ir_model), 32'(wr_cnt), writes ? 32'd1 : 32'd0);
        check($sformatf("bad_%h", ir_model), 32'(bad_cnt), (k == K_BAD) ? 32'd1 : 32'd0);
        check($sformatf("loads_%h", ir_model), 32'(loads_cnt), (k == K_CMP) ? 32'd1 : 32'd0);
        check($sformatf("dp_in_leak_%h", ir_model), 32'(leak), 32'd0);
        if (writes)
            check($sformatf("writenum_%h", ir_model), 32'(last_wn),
                  (k == K_MOVI) ? 32'(ir_model[10:8]) : 32'(ir_model[7:5]));
        if (k == K_MOVI)
            check($sformatf("dp_in_%h", ir_model), 32'(last_dp), {16'h0, {8{ir_model[7]}}, ir_model[7:0]});
        if (k == K_CMP)
            check($sformatf("zflag_%h", ir_model), 32'(zf), 32'(mz));
        for (int r = 0; r < 8; r++)
            check($sformatf("R%0d_after_%h", r, ir_model), 32'(rf[r]), 32'(mreg[r]));
    endtask

    initial begin
        int          wcount;
        logic [15:0] instr;
        logic [2:0]  rn, rd, rm;
        logic [1:0]  sh, op;
        int          pick;

        rst_n = 1'b1;
        bus.in = 16'h0; bus.load = 1'b0; bus.s = 1'b0;
        ir_model = 16'h0;
        mz = 1'b0;

        // Asynchronous reset between edges, held across three edges.
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_w", 32'(bus.w), 32'd1);
        check("rst_async_ctl", {27'h0, bus.write, bus.loada, bus.loadb, bus.loadc, bus.loads}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_held_w", 32'(bus.w), 32'd1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // IR is zero after reset: s without load executes an undefined word.
        exec_and_check(16'h0000, 1'b0, -1, 16'h0);

        // Seed every register, then the directed immediates.
        for (int r = 0; r < 8; r++)
            exec_and_check({3'b110, 2'b10, 3'(r), 8'($urandom)}, 1'b1, -1, 16'h0);
        exec_and_check(16'hD007, 1'b1, -1, 16'h0);
        exec_and_check(16'hD5FE, 1'b1, -1, 16'h0);
        exec_and_check(16'hD102, 1'b1, -1, 16'h0);

        // ADD R2,R1,R0,LSL#1 with per-step control checks.
        bus.in = 16'hA148; bus.load = 1'b1; bus.s = 1'b1;
        tick();
        bus.load = 1'b0; bus.s = 1'b0;
        check("add_decode_w", 32'(bus.w), 32'd0);
        tick();
        check("add_get_a", {26'h0, bus.readnum, bus.loada, bus.loadb, bus.write},
              {26'h0, 3'd1, 1'b1, 1'b0, 1'b0});
        tick();
        check("add_get_b", {26'h0, bus.readnum, bus.loada, bus.loadb, bus.write},
              {26'h0, 3'd0, 1'b0, 1'b1, 1'b0});
        tick();
        check("add_exec", {23'h0, bus.shift, bus.ALUop, bus.asel, bus.bsel, bus.loadc, bus.loads, bus.write},
              {23'h0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        tick();
        check("add_write_reg", {27'h0, bus.writenum, bus.write, bus.vsel},
              {27'h0, 3'd2, 1'b1, 1'b0});
        tick();
        check("add_w_back", 32'(bus.w), 32'd1);
        ir_model = 16'hA148;
        model_exec(16'hA148);
        check("add_r2_value", 32'(rf[2]), 32'd16);

        // CMP R3,R1 with a load attempted during EXEC; the rerun must still be CMP.
        exec_and_check(16'hAB01, 1'b1, 3, 16'hD0FF);
        exec_and_check(16'h0000, 1'b0, -1, 16'h0);
        exec_and_check(16'h0000, 1'b1, -1, 16'h0);

        // Reset during GET_B of an ADD aborts it with no write.
        exec_and_check(16'hD1FF, 1'b1, -1, 16'h0);
        bus.in = 16'hA148; bus.load = 1'b1; bus.s = 1'b1;
        tick();
        bus.load = 1'b0; bus.s = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("abort_w", 32'(bus.w), 32'd1);
        wcount = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.write) wcount++;
        end
        check("abort_no_write", 32'(wcount), 32'd0);
        rst_n = 1'b1;
        ir_model = 16'h0;
        tick();
        check("abort_r2_kept", 32'(rf[2]), 32'(mreg[2]));

        // Randomised mix against the model.
        for (int n = 0; n < 150; n++) begin
            rn = 3'($urandom_range(7, 0)); rd = 3'($urandom_range(7, 0));
            rm = 3'($urandom_range(7, 0)); sh = 2'($urandom_range(3, 0));
            op = 2'($urandom_range(3, 0));
            pick = $urandom_range(9, 0);
            if (pick < 2)       instr = {3'b110, 2'b10, rn, 8'($urandom)};
            else if (pick < 3)  instr = {3'b110, 2'b00, rn, rd, sh, rm};
            else if (pick < 8)  instr = {3'b101, op, rn, rd, sh, rm};
            else begin
                instr = 16'($urandom);
                while (classify(instr) != K_BAD) instr = 16'($urandom);
            end
            if (rn == rm && pick == 4) instr = {3'b101, 2'b01, rn, rd, 2'b00, rn};
            exec_and_check(instr, ($urandom_range(7, 0) != 0), -1, 16'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
